// File: rtl/mul_pkg.sv
// Shared definitions for the sequential radix-4 Booth multiplier.
//   state_e         : controller states (idle, iterating, result pulse)
//   booth_digit_e   : recoded Booth digit selecting the addend
//   steps_of()      : number of bit-pair iterations for a given operand width
//   cnt_width_of()  : width of the iteration counter for a given operand width
//   booth_digit()   : maps a 3-bit window {q[1], q[0], q[-1]} to a digit
package mul_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    typedef enum logic [2:0] {
        DigZero,
        DigPm,
        DigP2m,
        DigNm,
        DigN2m
    } booth_digit_e;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned STEPS         = DEFAULT_WIDTH / 2;

    function automatic int unsigned steps_of(int unsigned width);
        return width / 2;
    endfunction

    // Counter must hold the value STEPS itself, hence STEPS+1 codes.
    function automatic int unsigned cnt_width_of(int unsigned width);
        return $clog2(width / 2 + 1);
    endfunction

    function automatic booth_digit_e booth_digit(logic [2:0] window);
        booth_digit_e d;
        d = DigZero;
        unique case (window)
            3'b000, 3'b111: d = DigZero;
            3'b001, 3'b010: d = DigPm;
            3'b011:         d = DigP2m;
            3'b100:         d = DigN2m;
            3'b101, 3'b110: d = DigNm;
            default:        d = DigZero;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_pair_recoder.sv
// Combinational radix-4 Booth recoder.
// Ports:
//   window  in  3        {q[1], q[0], q[-1]} of the current bit pair
//   m_ext   in  WIDTH+2  multiplicand sign-extended to the accumulator width
//   addend  out WIDTH+2  d*M for d in {-2,-1,0,+1,+2}
module booth_pair_recoder
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic        [2:0]     window,
    input  logic signed [WIDTH+1:0] m_ext,
    output logic signed [WIDTH+1:0] addend
);

    booth_digit_e digit;

    assign digit = booth_digit(window);

    // |2M| <= 2^WIDTH always fits in WIDTH+2 signed bits, so no overflow here.
    always_comb begin
        addend = '0;
        unique case (digit)
            DigZero: addend = '0;
            DigPm:   addend = m_ext;
            DigP2m:  addend = m_ext <<< 1;
            DigNm:   addend = -m_ext;
            DigN2m:  addend = -(m_ext <<< 1);
            default: addend = '0;
        endcase
    end

endmodule

// File: rtl/mul_32_seq.sv
// Sequential signed WIDTH x WIDTH multiplier, radix-4 Booth, one bit pair per clock.
// Ports:
//   clk           in  1        rising-edge clock
//   clr_n         in  1        asynchronous active-low reset
//   start         in  1        request, sampled only while idle
//   multiplicand  in  WIDTH    signed M, captured on the accepting edge
//   multiplier    in  WIDTH    signed Q, captured on the accepting edge
//   busy          out 1        high while iterating or presenting the result
//   done          out 1        one-cycle pulse, product valid
//   product       out 2*WIDTH  signed {HI, LO}, held until the next accepted start
module mul_32_seq
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned STEP_CNT = steps_of(WIDTH);
    localparam int unsigned CNT_W    = cnt_width_of(WIDTH);
    localparam int unsigned SHIFT_W  = 2 * WIDTH + 3;

    state_e                  state_q;
    logic signed [WIDTH+1:0] acc_q;
    logic [WIDTH-1:0]        qreg_q;
    logic                    q_m1_q;
    logic [WIDTH-1:0]        mreg_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [2*WIDTH-1:0]      product_q;
    logic                    busy_q;
    logic                    done_q;

    logic signed [WIDTH+1:0]   m_ext;
    logic signed [WIDTH+1:0]   addend;
    logic signed [WIDTH+1:0]   acc_sum;
    logic signed [SHIFT_W-1:0] shift_in;
    logic signed [SHIFT_W-1:0] shifted;
    logic signed [WIDTH+1:0]   acc_new;
    logic [WIDTH-1:0]          qreg_new;
    logic                      q_m1_new;

    booth_pair_recoder #(
        .WIDTH (WIDTH)
    ) u_recoder (
        .window ({qreg_q[1:0], q_m1_q}),
        .m_ext  (m_ext),
        .addend (addend)
    );

    // One Booth step: add d*M, then arithmetic shift {acc, q, q_m1} right by two.
    always_comb begin
        m_ext    = {{2{mreg_q[WIDTH-1]}}, mreg_q};
        acc_sum  = acc_q + addend;
        shift_in = {acc_sum, qreg_q, q_m1_q};
        shifted  = shift_in >>> 2;
        acc_new  = shifted[SHIFT_W-1 -: (WIDTH + 2)];
        qreg_new = shifted[WIDTH:1];
        q_m1_new = shifted[0];
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            qreg_q    <= '0;
            q_m1_q    <= 1'b0;
            mreg_q    <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        acc_q   <= '0;
                        qreg_q  <= multiplier;
                        q_m1_q  <= 1'b0;
                        mreg_q  <= multiplicand;
                        cnt_q   <= CNT_W'(STEP_CNT);
                        state_q <= StRun;
                        busy_q  <= 1'b1;
                    end
                end
                StRun: begin
                    acc_q  <= acc_new;
                    qreg_q <= qreg_new;
                    q_m1_q <= q_m1_new;
                    cnt_q  <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        // Low 2*WIDTH bits of {acc, q} hold the exact signed product.
                        product_q <= {acc_new[WIDTH-1:0], qreg_new};
                        state_q   <= StDone;
                        done_q    <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_mul_32_seq.sv
// Scoreboard bench for mul_32_seq: stimulus pushes expected products into a queue,
// a negedge monitor pops and compares on every done pulse.
module tb_mul_32_seq;

    localparam int unsigned W       = 32;
    localparam int unsigned LATENCY = W / 2;

    logic          clk;
    logic          clr_n;
    logic          start;
    logic [W-1:0]  multiplicand;
    logic [W-1:0]  multiplier;
    logic          busy;
    logic          done;
    logic [2*W-1:0] product;

    mul_32_seq #(
        .WIDTH (W)
    ) dut (
        .clk          (clk),
        .clr_n        (clr_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int accept_cyc = 0;
    int done_count = 0;
    int accepted   = 0;
    logic [2*W-1:0] exp_q[$];
    logic           prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (clr_n && done) begin
            done_count++;
            if (prev_done) begin
                compared++;
                mismatched++;
                $display("FAIL done_width: done high for more than one cycle");
            end
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_done: product 0x%h with nothing outstanding", product);
            end else begin
                check("product", product, exp_q.pop_front());
            end
        end
        prev_done = clr_n && done;
    end

    // Waits for idle, then presents operands for one accepting edge.
    task automatic issue(input logic [W-1:0] m, input logic [W-1:0] q,
                         input logic [2*W-1:0] exp, input bit push);
        bit idle = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (!busy) begin
                idle = 1;
                break;
            end
        end
        if (!idle) begin
            $display("FAIL idle_timeout: busy never dropped");
            $fatal(1, "idle timeout");
        end
        start        = 1'b1;
        multiplicand = m;
        multiplier   = q;
        if (push) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        accept_cyc   = cyc;
        accepted++;
        start        = 1'b0;
        multiplicand = $urandom();
        multiplier   = $urandom();
        check("busy_rise", {63'b0, busy}, 64'd1);
    endtask

    // Waits (bounded) for done and checks the edge distance from the accepting edge.
    task automatic wait_done(input string name);
        bit seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                seen = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!seen) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: no done within bound", name);
        end else begin
            check({name, "_latency"}, 64'(cyc - accept_cyc), 64'(LATENCY));
        end
    endtask

    typedef struct {
        logic [W-1:0]   m;
        logic [W-1:0]   q;
        logic [2*W-1:0] p;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{32'd7,         32'd6,         64'h0000_0000_0000_002A};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[2] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[3] = '{32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000};
        vecs[4] = '{32'h0000_0000, 32'h1234_5678, 64'h0000_0000_0000_0000};

        clr_n        = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {63'b0, busy}, 64'd0);
        check("reset_done", {63'b0, done}, 64'd0);
        check("reset_product", product, 64'd0);
        clr_n = 1'b1;

        // Directed vectors.
        foreach (vecs[i]) begin
            issue(vecs[i].m, vecs[i].q, vecs[i].p, 1);
            check("done_low_after_accept", {63'b0, done}, 64'd0);
            wait_done("directed");
        end

        // Product held while idle.
        repeat (5) @(posedge clk);
        #1;
        check("idle_busy", {63'b0, busy}, 64'd0);
        check("product_hold", product, 64'd0);

        // Start while busy is ignored.
        issue(32'd3, 32'd5, 64'd15, 1);
        repeat (4) @(posedge clk);
        #1;
        start        = 1'b1;
        multiplicand = 32'd9;
        multiplier   = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("ignore");
        repeat (20) @(posedge clk);
        #1;
        check("no_second_op_busy", {63'b0, busy}, 64'd0);
        check("ignore_product_hold", product, 64'd15);

        // Reset mid-operation aborts with no done.
        issue(32'h1234, 32'h5678, 64'd0, 0);
        repeat (7) @(posedge clk);
        #1;
        clr_n = 1'b0;
        #1;
        check("abort_busy", {63'b0, busy}, 64'd0);
        check("abort_done", {63'b0, done}, 64'd0);
        check("abort_product", product, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        clr_n = 1'b1;
        accepted--;
        repeat (20) @(posedge clk);
        issue(32'd2, 32'd3, 64'd6, 1);
        wait_done("after_reset");

        // Random back-to-back at earliest allowed start.
        for (int i = 0; i < 1500; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic signed [2*W-1:0] r;
            a = $urandom();
            b = $urandom();
            r = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
            issue(a, b, r, 1);
            wait_done("random");
        end

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("done_per_start", 64'(done_count), 64'(accepted));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
